// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int W = 8;
  localparam int ITER = 8;
  localparam logic [7:0] DBZ_Q = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done request and result bundle for the divider.
interface seq_restoring_divider_if;
  import div_pkg::*;

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient,
    input  remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient,
    output remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_sub.sv
// 8-bit ripple-borrow subtractor: difference = a - b - bin.
module eight_bit_full_subtractor (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] difference,
  output logic       bout
);

  logic [8:0] br;

  always_comb begin
    br = '0;
    difference = '0;
    br[0] = bin;
    for (int i = 0; i < 8; i++) begin
      difference[i] = a[i] ^ b[i] ^ br[i];
      br[i+1] = (~a[i] & b[i])
              | (~(a[i] ^ b[i]) & br[i]);
    end
  end

  assign bout = br[8];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned 8-bit restoring divider, one quotient bit per clock.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  seq_restoring_divider_if.slave bus
);

  if (WIDTH != 8) begin : g_bad_width
    $error("seq_restoring_divider: WIDTH must be 8");
  end

  state_t     state;
  state_t     state_nx;
  logic [7:0] q_r;
  logic [7:0] r_r;
  logic [7:0] d_r;
  logic [2:0] count;
  logic [7:0] quo;
  logic [7:0] rem;
  logic       dbz;
  logic       done_r;
  logic [7:0] s;
  logic [7:0] diff;
  logic       bout;
  logic       accept;

  assign s = {r_r[6:0], q_r[7]};

  eight_bit_full_subtractor u_sub (
    .a          (s),
    .b          (d_r),
    .bin        (1'b0),
    .difference (diff),
    .bout       (bout)
  );

  // a start coinciding with the done pulse is dropped
  assign accept = bus.start && !done_r;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nx = (bus.divisor == 8'd0)
                   ? S_FIN : S_RUN;
      end
      S_RUN: begin
        if (count == 3'(ITER - 1))
          state_nx = S_FIN;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r    <= '0;
      r_r    <= '0;
      d_r    <= '0;
      count  <= '0;
      quo    <= '0;
      rem    <= '0;
      dbz    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == S_FIN);
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            q_r   <= bus.dividend;
            d_r   <= bus.divisor;
            r_r   <= '0;
            count <= '0;
            dbz   <= 1'b0;
          end
        end
        S_RUN: begin
          if (!bout) begin
            r_r <= diff;
            q_r <= {q_r[6:0], 1'b1};
          end else begin
            r_r <= s;
            q_r <= {q_r[6:0], 1'b0};
          end
          count <= count + 3'd1;
        end
        S_FIN: begin
          if (d_r == 8'd0) begin
            quo <= DBZ_Q;
            rem <= q_r;
            dbz <= 1'b1;
          end else begin
            quo <= q_r;
            rem <= r_r;
          end
        end
        default: ;
      endcase
    end
  end

  // before iteration k the remainder is below 2^k, so bit 7 never shifts out
  always_ff @(posedge clk) begin
    if (rst_n && state == S_RUN)
      a_r_msb: assert (r_r[7] == 1'b0);
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_r;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider.
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         t0;
    int         lat;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  exp_t sbq[$];
  exp_t e;

  seq_restoring_divider_if bus ();

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL spurious_done at cycle %0d: got done, want none", cyc);
      end else begin
        e = sbq.pop_front();
        check("quotient", 32'(bus.quotient), 32'(e.q));
        check("remainder", 32'(bus.remainder), 32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
        check("latency", 32'(cyc - e.t0), 32'(e.lat));
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic issue(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] q,
                       input logic [7:0] r,
                       input logic z,
                       input bit push);
    exp_t x;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = ~a;
    bus.divisor = ~b;
    x.q = q;
    x.r = r;
    x.z = z;
    x.t0 = cyc;
    x.lat = (b == 8'd0) ? 1 : 9;
    if (push) sbq.push_back(x);
  endtask

  task automatic wait_done(input bit coincide);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_mis++;
      $display("FAIL done_timeout: got no done, want done");
    end
    if (coincide) begin
      bus.start = 1'b1;
      bus.dividend = 8'd1;
      bus.divisor = 8'd1;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
    check({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
  endtask

  vec_t vecs[$] = '{
    '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0},
    '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0},
    '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0},
    '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0},
    '{8'd13,  8'd0,   8'hFF,  8'd13,  1'b1},
    '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0},
    '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0},
    '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1},
    '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0},
    '{8'd7,   8'd2,   8'd3,   8'd1,   1'b0},
    '{8'd129, 8'd128, 8'd1,   8'd1,   1'b0}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor = 8'd3;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset");
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q,
            vecs[i].r, vecs[i].z, 1'b1);
      wait_done(1'b0);
    end

    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(1'b0);
    repeat (12) @(posedge clk);
    #1;

    issue(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("midrun_reset");
    repeat (12) @(posedge clk);
    #1;
    issue(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 1'b1);
    wait_done(1'b0);

    issue(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b1);
    wait_done(1'b1);
    @(negedge clk);
    check("coincide_start_busy", 32'(bus.busy), 32'd0);
    repeat (12) @(posedge clk);
    #1;

    for (int a = 3; a < 256; a += 23) begin
      for (int b = 1; b < 256; b += 11) begin
        issue(8'(a), 8'(b), 8'(a / b), 8'(a % b),
              1'b0, 1'b1);
        wait_done(1'b0);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
